// File: rtl/status_register.sv
// 6502 processor status register (P) with IRQ/NMI synchronisation and I-mask delay.
// P updates 1 cycle after a strobe; interrupt outputs are decoded from registers only.
module status_register #(
    parameter logic [7:0] RESET_P = 8'h34
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] alu_flags,
    input  logic [7:0] alu_flags_ena,
    input  logic       flags_we,
    input  logic       plp_we,
    input  logic [7:0] plp_data,
    input  logic       int_enter,
    input  logic       push_b,
    input  logic       instr_boundary,
    input  logic       int_ack,
    input  logic       irq_n,
    input  logic       nmi_n,
    output logic [7:0] p_out,
    output logic [7:0] p_push,
    output logic       int_req,
    output logic       int_is_nmi
);

    localparam int unsigned BIT_D = 3;
    localparam int unsigned BIT_I = 2;

    logic [7:0] p_q, p_d;
    logic       irq_m_q, irq_m_d;
    logic       irq_s_q, irq_s_d;
    logic       nmi_m_q, nmi_m_d;
    logic       nmi_s_q, nmi_s_d;
    logic       nmi_d_q, nmi_d_d;
    logic       nmi_pend_q, nmi_pend_d;
    logic       irq_mask_q, irq_mask_d;

    always_comb begin
        p_d = p_q;
        if (flags_we) begin
            p_d = (p_q & ~alu_flags_ena) | (alu_flags & alu_flags_ena);
        end
        if (plp_we) begin
            p_d = plp_data;
        end
        // Bits 5 and 4 have no storage meaning; they always read back as 1.
        p_d[5] = 1'b1;
        p_d[4] = 1'b1;
        if (int_enter) begin
            p_d[BIT_I] = 1'b1;
            p_d[BIT_D] = 1'b0;
        end
    end

    always_comb begin
        irq_m_d = irq_n;
        irq_s_d = irq_m_q;
        nmi_m_d = nmi_n;
        nmi_s_d = nmi_m_q;
        nmi_d_d = nmi_s_q;

        // A fresh falling edge beats an acknowledge landing in the same cycle.
        nmi_pend_d = nmi_pend_q;
        if (nmi_d_q && !nmi_s_q) begin
            nmi_pend_d = 1'b1;
        end else if (int_ack && nmi_pend_q) begin
            nmi_pend_d = 1'b0;
        end

        // Sampling the pre-update I gives the one-instruction delay on CLI/SEI/PLP.
        irq_mask_d = irq_mask_q;
        if (instr_boundary) begin
            irq_mask_d = p_q[BIT_I];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q        <= RESET_P;
            irq_m_q    <= 1'b1;
            irq_s_q    <= 1'b1;
            nmi_m_q    <= 1'b1;
            nmi_s_q    <= 1'b1;
            nmi_d_q    <= 1'b1;
            nmi_pend_q <= 1'b0;
            irq_mask_q <= 1'b1;
        end else begin
            p_q        <= p_d;
            irq_m_q    <= irq_m_d;
            irq_s_q    <= irq_s_d;
            nmi_m_q    <= nmi_m_d;
            nmi_s_q    <= nmi_s_d;
            nmi_d_q    <= nmi_d_d;
            nmi_pend_q <= nmi_pend_d;
            irq_mask_q <= irq_mask_d;
        end
    end

    always_comb begin
        p_out      = p_q | 8'h30;
        p_push     = {p_q[7:6], 1'b1, push_b, p_q[3:0]};
        int_is_nmi = nmi_pend_q;
        int_req    = nmi_pend_q | (~irq_s_q & ~irq_mask_q);
    end

endmodule

// File: tb/tb_status_register.sv
// Directed and random checks of status_register against a cycle-level reference model.
module tb_status_register;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] alu_flags, alu_flags_ena, plp_data;
    logic       flags_we, plp_we, int_enter, push_b, instr_boundary, int_ack;
    logic       irq_n, nmi_n;
    logic [7:0] p_out, p_push;
    logic       int_req, int_is_nmi;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: architectural P, mask, NMI latch, and pin sample history
    // (index 0 = sample at the most recent edge).
    logic [7:0] m_p;
    bit         m_mask, m_pend;
    bit         irq_h [2];
    bit         nmi_h [3];

    status_register #(.RESET_P(8'h34)) dut (
        .clk(clk), .rst(rst),
        .alu_flags(alu_flags), .alu_flags_ena(alu_flags_ena), .flags_we(flags_we),
        .plp_we(plp_we), .plp_data(plp_data), .int_enter(int_enter), .push_b(push_b),
        .instr_boundary(instr_boundary), .int_ack(int_ack),
        .irq_n(irq_n), .nmi_n(nmi_n),
        .p_out(p_out), .p_push(p_push), .int_req(int_req), .int_is_nmi(int_is_nmi)
    );

    always #5 clk = ~clk;

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_p    = 8'h34;
        m_mask = 1'b1;
        m_pend = 1'b0;
        foreach (irq_h[i]) irq_h[i] = 1'b1;
        foreach (nmi_h[i]) nmi_h[i] = 1'b1;
    endtask

    task automatic check_all();
        chk8("p_out", p_out, m_p);
        chk8("p_push", p_push, {m_p[7:6], 1'b1, push_b, m_p[3:0]});
        chk1("int_req", int_req, m_pend || (!irq_h[1] && !m_mask));
        chk1("int_is_nmi", int_is_nmi, m_pend);
    endtask

    // One clock: advance the model with the inputs present at the edge, then compare.
    task automatic step();
        logic [7:0] np;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            np = m_p;
            if (flags_we) np = (np & ~alu_flags_ena) | (alu_flags & alu_flags_ena);
            if (plp_we) np = plp_data;
            np = np | 8'h30;
            if (int_enter) np = (np | 8'h04) & 8'hF7;
            if (nmi_h[2] && !nmi_h[1]) m_pend = 1'b1;
            else if (int_ack && m_pend) m_pend = 1'b0;
            if (instr_boundary) m_mask = m_p[2];
            m_p = np;
            nmi_h[2] = nmi_h[1]; nmi_h[1] = nmi_h[0]; nmi_h[0] = nmi_n;
            irq_h[1] = irq_h[0]; irq_h[0] = irq_n;
        end
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        flags_we = 0; plp_we = 0; int_enter = 0; instr_boundary = 0; int_ack = 0;
        alu_flags = 8'h00; alu_flags_ena = 8'h00; plp_data = 8'h00;
    endtask

    initial begin
        idle_inputs();
        rst = 1; push_b = 1; irq_n = 1; nmi_n = 1;
        model_reset();
        #2;
        check_all();
        chk8("reset_p_out", p_out, 8'h34);
        chk8("reset_push_b1", p_push, 8'h34);
        push_b = 0; #1;
        chk8("reset_push_b0", p_push, 8'h24);
        step();
        rst = 0;
        step();

        // ALU commit under per-bit enable
        flags_we = 1; alu_flags = 8'hC3; alu_flags_ena = 8'hC3;
        step();
        chk8("flags_c3", p_out, 8'hF7);
        idle_inputs();

        // PLP beats a simultaneous ALU commit
        plp_we = 1; plp_data = 8'h00; flags_we = 1; alu_flags = 8'hFF; alu_flags_ena = 8'hFF;
        step();
        chk8("plp_over_flags", p_out, 8'h30);
        idle_inputs();

        // Interrupt entry sets I and clears D
        plp_we = 1; plp_data = 8'h08;
        step();
        chk8("plp_d_set", p_out, 8'h38);
        idle_inputs();
        int_enter = 1; push_b = 0;
        step();
        chk8("int_enter_p", p_out, 8'h34);
        chk8("int_enter_push", p_push, 8'h24);
        idle_inputs();

        // CLI with IRQ held low: recognised only after the following boundary
        irq_n = 0;
        step(); step();
        flags_we = 1; alu_flags_ena = 8'h04; alu_flags = 8'h00; instr_boundary = 1;
        step();
        chk1("cli_same_boundary", int_req, 1'b0);
        idle_inputs();
        step(); step();
        chk1("cli_before_next", int_req, 1'b0);
        instr_boundary = 1;
        step();
        chk1("cli_next_boundary", int_req, 1'b1);
        idle_inputs();
        irq_n = 1;
        flags_we = 1; alu_flags_ena = 8'h04; alu_flags = 8'h04; instr_boundary = 1;
        step();
        idle_inputs();
        instr_boundary = 1;
        step();
        idle_inputs();
        step(); step();
        chk1("irq_released", int_req, 1'b0);

        // NMI edge, acknowledge, no retrigger while held low
        nmi_n = 0;
        step();
        chk1("nmi_edge1", int_req, 1'b0);
        step();
        chk1("nmi_edge2", int_req, 1'b0);
        step();
        chk1("nmi_edge3_req", int_req, 1'b1);
        chk1("nmi_edge3_is_nmi", int_is_nmi, 1'b1);
        int_ack = 1;
        step();
        chk1("nmi_acked", int_is_nmi, 1'b0);
        int_ack = 0;
        repeat (4) step();
        chk1("nmi_no_retrigger", int_req, 1'b0);

        // New edge on the same cycle as the previous NMI's acknowledge
        nmi_n = 1; repeat (3) step();
        nmi_n = 0; repeat (3) step();
        chk1("nmi_second_pend", int_is_nmi, 1'b1);
        nmi_n = 1; repeat (3) step();
        nmi_n = 0; step(); step();
        int_ack = 1;
        step();
        chk1("nmi_set_beats_ack", int_is_nmi, 1'b1);
        int_ack = 0;

        // Asynchronous reset mid-sequence
        plp_we = 1; plp_data = 8'hCB;
        step();
        idle_inputs();
        @(negedge clk);
        rst = 1; #1;
        model_reset();
        check_all();
        chk8("mid_rst_p_out", p_out, 8'h34);
        chk1("mid_rst_int_req", int_req, 1'b0);
        chk1("mid_rst_is_nmi", int_is_nmi, 1'b0);
        step();
        rst = 0; nmi_n = 1; irq_n = 1;
        step();

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            rst            = ($urandom_range(0, 99) == 0);
            flags_we       = ($urandom_range(0, 2) == 0);
            alu_flags      = 8'($urandom);
            alu_flags_ena  = 8'($urandom);
            plp_we         = ($urandom_range(0, 5) == 0);
            plp_data       = 8'($urandom);
            int_enter      = ($urandom_range(0, 7) == 0);
            push_b         = 1'($urandom);
            instr_boundary = ($urandom_range(0, 3) == 0);
            int_ack        = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) == 0) irq_n = ~irq_n;
            if ($urandom_range(0, 7) == 0) nmi_n = ~nmi_n;
            step();
        end
        rst = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
